// File: rtl/ascon_permutation_xor_if.sv
// ASCON shared types/constants and the datapath control/data bundle.
// The external sequencer drives the master side; the datapath core is the slave.
package ascon_pack;

  // S0 is element 0 and sits in the most significant 64 bits when flattened.
  typedef logic [0:4][63:0] type_state;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

endpackage

interface ascon_permutation_xor_if;
  import ascon_pack::*;

  type_state    state_i;
  logic [3:0]   round_i;
  logic         en_i;
  logic         en_out_cipher_i;
  logic         en_out_tag_i;
  logic         state_mode_i;
  logic [127:0] key_i;
  logic         en_xor_key_begin_i;
  logic         en_xor_lsb_i;
  logic         en_xor_key_end_i;
  logic [63:0]  data_i;
  logic         en_xor_data_i;
  type_state    state_o;
  logic [63:0]  cipher_o;
  logic [127:0] tag_o;

  modport master (
    output state_i, round_i, en_i, en_out_cipher_i, en_out_tag_i, state_mode_i,
           key_i, en_xor_key_begin_i, en_xor_lsb_i, en_xor_key_end_i,
           data_i, en_xor_data_i,
    input  state_o, cipher_o, tag_o
  );

  modport slave (
    input  state_i, round_i, en_i, en_out_cipher_i, en_out_tag_i, state_mode_i,
           key_i, en_xor_key_begin_i, en_xor_lsb_i, en_xor_key_end_i,
           data_i, en_xor_data_i,
    output state_o, cipher_o, tag_o
  );

endinterface

// File: rtl/ascon_permutation_xor.sv
// ASCON-128 datapath: one permutation round per clock with data/key/domain XOR
// injections around it, plus ciphertext and tag capture registers.
module ascon_permutation_xor
  import ascon_pack::*;
(
  input logic                    clock_i,
  input logic                    resetb_i,
  ascon_permutation_xor_if.slave bus
);

  type_state    state_q;
  type_state    mux_s;
  type_state    begin_s;
  type_state    const_s;
  type_state    sbox_s;
  type_state    lin_s;
  type_state    end_s;
  logic [63:0]  cipher_q;
  logic [127:0] tag_q;
  logic [4:0]   col_s;
  logic [4:0]   sub_s;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Round input selection followed by the pre-round data and key injections.
  always_comb begin
    mux_s   = bus.state_mode_i ? state_q : bus.state_i;
    begin_s = mux_s;
    if (bus.en_xor_data_i) begin
      begin_s[0] = begin_s[0] ^ bus.data_i;
    end
    if (bus.en_xor_key_begin_i) begin
      begin_s[1] = begin_s[1] ^ bus.key_i[127:64];
      begin_s[2] = begin_s[2] ^ bus.key_i[63:0];
    end
  end

  always_comb begin
    const_s       = begin_s;
    const_s[2][7:0] = begin_s[2][7:0] ^ {~bus.round_i, bus.round_i};
  end

  // Each bit position forms a 5-bit column with S0 as its most significant bit.
  always_comb begin
    sbox_s = '0;
    col_s  = '0;
    sub_s  = '0;
    for (int i = 0; i < 64; i++) begin
      col_s = {const_s[0][i], const_s[1][i], const_s[2][i], const_s[3][i], const_s[4][i]};
      sub_s = SBOX[col_s];
      sbox_s[0][i] = sub_s[4];
      sbox_s[1][i] = sub_s[3];
      sbox_s[2][i] = sub_s[2];
      sbox_s[3][i] = sub_s[1];
      sbox_s[4][i] = sub_s[0];
    end
  end

  always_comb begin
    lin_s = '0;
    for (int w = 0; w < 5; w++) begin
      lin_s[w] = sbox_s[w] ^ ror64(sbox_s[w], ROT_A[w]) ^ ror64(sbox_s[w], ROT_B[w]);
    end
  end

  always_comb begin
    end_s = lin_s;
    if (bus.en_xor_key_end_i) begin
      end_s[3] = end_s[3] ^ bus.key_i[127:64];
      end_s[4] = end_s[4] ^ bus.key_i[63:0];
    end
    if (bus.en_xor_lsb_i) begin
      end_s[4][0] = ~end_s[4][0];
    end
  end

  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) begin
      state_q <= '0;
    end else if (bus.en_i) begin
      state_q <= end_s;
    end
  end

  // Ciphertext is the post-injection S0, so it captures on the same cycle the
  // plaintext is absorbed, whether or not the state register advances.
  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) begin
      cipher_q <= '0;
    end else if (bus.en_out_cipher_i) begin
      cipher_q <= begin_s[0];
    end
  end

  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) begin
      tag_q <= '0;
    end else if (bus.en_out_tag_i) begin
      tag_q <= {state_q[3], state_q[4]};
    end
  end

  assign bus.state_o  = state_q;
  assign bus.cipher_o = cipher_q;
  assign bus.tag_o    = tag_q;

endmodule

// File: tb/tb_ascon_permutation_xor.sv
// Scoreboarded bench for the ASCON round datapath, ending with a full
// ASCON-128 encryption compared against a software-style reference.
`timescale 1ns/1ps
module tb_ascon_permutation_xor;
  import ascon_pack::*;

  localparam logic [63:0]  IV    = 64'h80400c0600000000;
  localparam logic [127:0] KEY   = 128'h8a55114d1cb6a9a2be263d4d7aecaaff;
  localparam logic [127:0] NONCE = 128'h4ed0ec0b98c529b7c8cddf37bcd0284a;
  localparam logic [63:0]  AD    = 64'h4120746f20428000;
  localparam logic [63:0]  PT1   = 64'h5244562061752054;
  localparam logic [63:0]  PT2   = 64'h6927626172206365;
  localparam logic [63:0]  PT3   = 64'h20736f6972203f80;

  typedef struct {
    logic [319:0] state;
    logic [3:0]   round;
    logic         en;
    logic         mode;
    logic         key_begin;
    logic         lsb;
    logic         key_end;
    logic         xor_data;
    logic         out_cipher;
    logic         out_tag;
    logic [63:0]  data;
    logic [127:0] key;
  } stim_t;

  typedef struct {
    logic [319:0] state;
    logic [63:0]  cipher;
    logic [127:0] tag;
  } expect_t;

  logic clock_i = 1'b0;
  logic resetb_i;

  ascon_permutation_xor_if bus ();

  ascon_permutation_xor dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .bus      (bus)
  );

  always #5 clock_i = ~clock_i;

  expect_t      sb_q[$];
  logic [319:0] m_state;
  logic [63:0]  m_cipher;
  logic [127:0] m_tag;
  int           checks;
  int           failures;
  int           cycle;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bitsliced ASCON round, written in the reference software form.
  function automatic logic [319:0] bench_perm_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x2 = x2 ^ {56'h0, ~r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] bench_perm(input logic [319:0] s, input int first);
    logic [319:0] t;
    t = s;
    for (int r = first; r < 12; r++) t = bench_perm_round(t, r[3:0]);
    return t;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [319:0] rnd320();
    return {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.state = '0; s.round = '0; s.en = 1'b0; s.mode = 1'b1;
    s.key_begin = 1'b0; s.lsb = 1'b0; s.key_end = 1'b0; s.xor_data = 1'b0;
    s.out_cipher = 1'b0; s.out_tag = 1'b0; s.data = '0; s.key = KEY;
    return s;
  endfunction

  function automatic stim_t random_stim();
    stim_t s;
    s.state = rnd320(); s.round = 4'($urandom_range(0, 15));
    s.en = 1'($urandom); s.mode = 1'($urandom);
    s.key_begin = 1'($urandom); s.lsb = 1'($urandom); s.key_end = 1'($urandom);
    s.xor_data = 1'($urandom); s.out_cipher = 1'($urandom); s.out_tag = 1'($urandom);
    s.data = rnd64(); s.key = {rnd64(), rnd64()};
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] actual, input logic [319:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_state = '0; m_cipher = '0; m_tag = '0;
  endtask

  // Drive one cycle, predict its outcome into the scoreboard, then retire it
  // against the registers one time unit after the edge.
  task automatic applyStimulus(input stim_t s);
    logic [319:0] a, nxt;
    expect_t      e, got;
    bus.state_i = s.state; bus.round_i = s.round; bus.en_i = s.en;
    bus.state_mode_i = s.mode; bus.en_xor_key_begin_i = s.key_begin;
    bus.en_xor_lsb_i = s.lsb; bus.en_xor_key_end_i = s.key_end;
    bus.en_xor_data_i = s.xor_data; bus.en_out_cipher_i = s.out_cipher;
    bus.en_out_tag_i = s.out_tag; bus.data_i = s.data; bus.key_i = s.key;
    a = s.mode ? m_state : s.state;
    if (s.xor_data)  a[319:256] = a[319:256] ^ s.data;
    if (s.key_begin) a[255:128] = a[255:128] ^ s.key;
    nxt = bench_perm_round(a, s.round);
    if (s.key_end) nxt[127:0] = nxt[127:0] ^ s.key;
    if (s.lsb)     nxt[0] = ~nxt[0];
    e.state  = s.en ? nxt : m_state;
    e.cipher = s.out_cipher ? a[319:256] : m_cipher;
    e.tag    = s.out_tag ? m_state[127:0] : m_tag;
    m_state = e.state; m_cipher = e.cipher; m_tag = e.tag;
    sb_q.push_back(e);
    @(posedge clock_i);
    #1;
    cycle++;
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 320'd0, 320'd1);
    end else begin
      got = sb_q.pop_front();
      checkOutput($sformatf("state@%0d", cycle), bus.state_o, got.state);
      checkOutput($sformatf("cipher@%0d", cycle), {256'd0, bus.cipher_o}, {256'd0, got.cipher});
      checkOutput($sformatf("tag@%0d", cycle), {192'd0, bus.tag_o}, {192'd0, got.tag});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checkOutput({tag, "_state"}, bus.state_o, 320'd0);
    checkOutput({tag, "_cipher"}, {256'd0, bus.cipher_o}, 320'd0);
    checkOutput({tag, "_tag"}, {192'd0, bus.tag_o}, 320'd0);
  endtask

  task automatic absorb_block(input logic [63:0] d, input logic capture, input logic last_ad);
    stim_t s;
    for (int r = 6; r < 12; r++) begin
      s = idle_stim(); s.en = 1'b1; s.round = r[3:0];
      s.xor_data = (r == 6); s.out_cipher = capture && (r == 6); s.data = d;
      s.lsb = last_ad && (r == 11);
      applyStimulus(s);
    end
  endtask

  initial begin
    stim_t        s;
    logic [319:0] x_state, ref_state, sw;
    logic [63:0]  c_ref [3];
    logic [127:0] tag_ref;
    logic [63:0]  d;
    checks = 0; failures = 0; cycle = 0;
    model_reset();

    // Reset holds everything at zero even with loads requested.
    resetb_i = 1'b1;
    s = idle_stim(); s.en = 1'b1; s.mode = 1'b0; s.state = rnd320();
    s.out_cipher = 1'b1; s.out_tag = 1'b1; s.xor_data = 1'b1; s.data = rnd64();
    bus.state_i = s.state; bus.round_i = 4'd0; bus.en_i = 1'b1; bus.state_mode_i = 1'b0;
    bus.en_xor_key_begin_i = 1'b0; bus.en_xor_lsb_i = 1'b0; bus.en_xor_key_end_i = 1'b0;
    bus.en_xor_data_i = 1'b1; bus.en_out_cipher_i = 1'b1; bus.en_out_tag_i = 1'b1;
    bus.data_i = s.data; bus.key_i = KEY;
    #2;
    check_zero_outputs("reset_initial");
    @(posedge clock_i);
    #1;
    check_zero_outputs("reset_with_en");
    resetb_i = 1'b0;

    s = idle_stim(); s.en = 1'b1; s.mode = 1'b0; s.state = '0; s.round = 4'd0;
    applyStimulus(s);
    checkOutput("zero_round_s0", {256'd0, bus.state_o[0]}, {256'd0, 64'h001e0f00000000f0});
    checkOutput("zero_round_s1", {256'd0, bus.state_o[1]}, {256'd0, 64'h00000001e0000770});
    checkOutput("zero_round_s4", {256'd0, bus.state_o[4]}, 320'd0);

    for (int i = 0; i < 3; i++) begin
      s = random_stim(); s.en = 1'b0; s.out_cipher = 1'b0; s.out_tag = 1'b0;
      applyStimulus(s);
    end

    foreach (ROT_A[i]) begin
      s = idle_stim(); s.en = 1'b1; s.round = 4'(i + 1);
      applyStimulus(s);
    end
    s = idle_stim(); s.en = 1'b1; s.round = 4'd15; applyStimulus(s);
    s = idle_stim(); s.en = 1'b1; s.round = 4'd12; applyStimulus(s);

    // Cipher capture without advancing the state.
    d = rnd64();
    x_state = m_state;
    s = idle_stim(); s.xor_data = 1'b1; s.out_cipher = 1'b1; s.data = d;
    applyStimulus(s);
    checkOutput("capture_cipher", {256'd0, bus.cipher_o}, {256'd0, x_state[319:256] ^ d});
    checkOutput("capture_state_held", bus.state_o, x_state);

    // Each XOR injection alone from the same loaded state.
    x_state = rnd320();
    ref_state = bench_perm_round(x_state, 4'd6);
    for (int sel = 0; sel < 4; sel++) begin
      s = idle_stim(); s.en = 1'b1; s.mode = 1'b0; s.state = x_state; s.round = 4'd6;
      s.key_begin = (sel == 1); s.key_end = (sel == 2); s.lsb = (sel == 3);
      applyStimulus(s);
      if (sel == 0) checkOutput("iso_plain", bus.state_o, ref_state);
      if (sel == 2) checkOutput("iso_key_end", bus.state_o, ref_state ^ {192'd0, KEY});
      if (sel == 3) checkOutput("iso_lsb", bus.state_o, ref_state ^ 320'd1);
    end

    // Abort an initialisation part way through.
    s = idle_stim(); s.en = 1'b1; s.mode = 1'b0; s.state = {IV, KEY, NONCE};
    applyStimulus(s);
    s.mode = 1'b1; s.round = 4'd1; s.out_cipher = 1'b1; s.out_tag = 1'b1;
    applyStimulus(s);
    resetb_i = 1'b1;
    #2;
    check_zero_outputs("reset_mid");
    model_reset();
    @(posedge clock_i);
    #1;
    resetb_i = 1'b0;

    sw = bench_perm({IV, KEY, NONCE}, 0);
    sw[127:0] = sw[127:0] ^ KEY;
    sw[319:256] = sw[319:256] ^ AD;
    sw = bench_perm(sw, 6);
    sw[0] = ~sw[0];
    sw[319:256] = sw[319:256] ^ PT1; c_ref[0] = sw[319:256]; sw = bench_perm(sw, 6);
    sw[319:256] = sw[319:256] ^ PT2; c_ref[1] = sw[319:256]; sw = bench_perm(sw, 6);
    sw[319:256] = sw[319:256] ^ PT3; c_ref[2] = sw[319:256];
    sw[255:128] = sw[255:128] ^ KEY;
    sw = bench_perm(sw, 0);
    sw[127:0] = sw[127:0] ^ KEY;
    tag_ref = sw[127:0];

    for (int r = 0; r < 12; r++) begin
      s = idle_stim(); s.en = 1'b1; s.state = {IV, KEY, NONCE}; s.round = r[3:0];
      s.mode = (r != 0); s.key_end = (r == 11);
      applyStimulus(s);
    end
    absorb_block(AD, 1'b0, 1'b1);
    absorb_block(PT1, 1'b1, 1'b0);
    absorb_block(PT2, 1'b1, 1'b0);
    for (int r = 0; r < 12; r++) begin
      s = idle_stim(); s.en = 1'b1; s.round = r[3:0];
      s.xor_data = (r == 0); s.key_begin = (r == 0); s.out_cipher = (r == 0);
      s.data = PT3; s.key_end = (r == 11);
      applyStimulus(s);
      if (r == 0) checkOutput("enc_c3", {256'd0, bus.cipher_o}, {256'd0, c_ref[2]});
    end
    s = idle_stim(); s.out_tag = 1'b1;
    applyStimulus(s);
    checkOutput("enc_tag", {192'd0, bus.tag_o}, {192'd0, tag_ref});

    // Ciphertexts C1/C2 are rechecked by replaying the same sequence.
    resetb_i = 1'b1;
    #2;
    model_reset();
    @(posedge clock_i);
    #1;
    resetb_i = 1'b0;
    for (int r = 0; r < 12; r++) begin
      s = idle_stim(); s.en = 1'b1; s.state = {IV, KEY, NONCE}; s.round = r[3:0];
      s.mode = (r != 0); s.key_end = (r == 11);
      applyStimulus(s);
    end
    absorb_block(AD, 1'b0, 1'b1);
    absorb_block(PT1, 1'b1, 1'b0);
    checkOutput("enc_c1", {256'd0, bus.cipher_o}, {256'd0, c_ref[0]});
    absorb_block(PT2, 1'b1, 1'b0);
    checkOutput("enc_c2", {256'd0, bus.cipher_o}, {256'd0, c_ref[1]});

    for (int i = 0; i < 24; i++) begin
      applyStimulus(random_stim());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
